// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath.
// Holds the default array geometry and the packed type for one row of
// bottom-row partial sums (column k at [k*SUM_WIDTH +: SUM_WIDTH]).
package systolic_pkg;

    localparam int DEFAULT_SYSTOLIC_WIDTH = 4;
    localparam int DEFAULT_SUM_WIDTH      = 16;
    localparam int DEFAULT_ROW_WIDTH      = DEFAULT_SYSTOLIC_WIDTH * DEFAULT_SUM_WIDTH;

    typedef logic [DEFAULT_ROW_WIDTH-1:0] sum_row_t;

endpackage

// File: rtl/systolic_result_collector_if.sv
// Valid/ready row stream from the result collector to the writeback stage.
//   out_data  : one aligned row of partial sums
//   out_valid : out_data holds a row
//   out_ready : consumer takes the row when out_valid & out_ready
// The master modport is the collector side, the slave modport the consumer.
interface systolic_result_collector_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_ROW_WIDTH
);

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sum_row_fifo.sv
// Synchronous first-word-fall-through FIFO for aligned sum rows.
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push       : write push_data this cycle (ignored when full without a pop)
//   pop_ready  : consumer ready; a pop happens when the FIFO is not empty
//   out_data   : storage at the read pointer
//   count      : rows stored; full/empty are derived from it
module sum_row_fifo #(
    parameter int  WIDTH       = 64,
    parameter int  DEPTH       = 4,
    localparam int PTR_WIDTH   = $clog2(DEPTH),
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   pop;
    logic                   write;

    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_WIDTH'(DEPTH));
    assign pop      = !empty && pop_ready;
    // When full, a same-cycle pop frees the slot the write lands in
    // (wr_ptr equals rd_ptr), so the push is still accepted.
    assign write    = push && (!full || pop);
    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            count_d = count_q + COUNT_WIDTH'(write) - COUNT_WIDTH'(pop);
        end
    end

    // Storage is reset too so out_data reads zero straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/systolic_result_collector.sv
// Collects the skewed bottom-row sums of the systolic array, deskews them
// into aligned rows and buffers them for the writeback stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   sum_in     : bottom-row sums, column k lags column 0 by k cycles
//   in_valid   : column 0 of a row is valid this cycle
//   flush      : synchronous clear of in-flight rows, FIFO and overflow
//   out_if     : valid/ready row stream (master side)
//   fifo_count : rows buffered
//   overflow   : sticky, set when an aligned row had to be dropped
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int  SYSTOLIC_WIDTH = DEFAULT_SYSTOLIC_WIDTH,
    parameter int  SUM_WIDTH      = DEFAULT_SUM_WIDTH,
    parameter int  FIFO_DEPTH     = 4,
    localparam int ROW_WIDTH      = SYSTOLIC_WIDTH * SUM_WIDTH,
    localparam int COUNT_WIDTH    = $clog2(FIFO_DEPTH + 1),
    localparam int VALID_STAGES   = SYSTOLIC_WIDTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ROW_WIDTH-1:0]       sum_in,
    input  logic                       in_valid,
    input  logic                       flush,
    systolic_result_collector_if.master out_if,
    output logic [COUNT_WIDTH-1:0]     fifo_count,
    output logic                       overflow
);

    logic [ROW_WIDTH-1:0]    aligned_row;
    logic                    aligned_valid;
    logic [VALID_STAGES-1:0] valid_q, valid_d;
    logic                    overflow_q, overflow_d;
    logic [ROW_WIDTH-1:0]    fifo_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;

    // Column k needs SYSTOLIC_WIDTH-1-k delay stages to line up with the
    // last column, which arrives latest and is used directly.
    for (genvar k = 0; k < SYSTOLIC_WIDTH; k++) begin : g_col
        localparam int DEPTH = SYSTOLIC_WIDTH - 1 - k;
        if (DEPTH == 0) begin : g_wire
            assign aligned_row[k*SUM_WIDTH +: SUM_WIDTH] = sum_in[k*SUM_WIDTH +: SUM_WIDTH];
        end else begin : g_chain
            logic [SUM_WIDTH-1:0] skew_q [DEPTH];
            logic [SUM_WIDTH-1:0] skew_d [DEPTH];

            always_comb begin
                skew_d[0] = sum_in[k*SUM_WIDTH +: SUM_WIDTH];
                for (int i = 1; i < DEPTH; i++) begin
                    skew_d[i] = skew_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        skew_q[i] <= '0;
                    end
                end else begin
                    skew_q <= skew_d;
                end
            end

            assign aligned_row[k*SUM_WIDTH +: SUM_WIDTH] = skew_q[DEPTH-1];
        end
    end

    // Flush empties the valid chain, which discards every row whose column 0
    // has already entered; the data chains keep shifting unqualified.
    always_comb begin
        valid_d = '0;
        if (!flush) begin
            valid_d[0] = in_valid;
            for (int i = 1; i < VALID_STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    assign aligned_valid = valid_q[VALID_STAGES-1];

    // The array cannot stall, so a push into a full FIFO with no pop is lost.
    assign pop  = !fifo_empty && out_if.out_ready;
    assign drop = aligned_valid && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    sum_row_fifo #(
        .WIDTH (ROW_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (aligned_valid),
        .push_data (aligned_row),
        .pop_ready (out_if.out_ready),
        .out_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_data  = fifo_data;
    assign out_if.out_valid = !fifo_empty;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector (4 columns x 16 bits,
// FIFO depth 4). The reference model keeps the issued rows by cycle and a
// queue of buffered rows; after every clock edge the DUT outputs are
// compared against that queue.
module tb_systolic_result_collector;

    import systolic_pkg::*;

    localparam int W     = 4;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int HIST  = 4096;

    logic          clk;
    logic          rst_n;
    sum_row_t      sum_in;
    logic          in_valid;
    logic          flush;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    systolic_result_collector_if #(.DATA_WIDTH(W * SW)) out_if ();

    systolic_result_collector #(
        .SYSTOLIC_WIDTH (W),
        .SUM_WIDTH      (SW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sum_in     (sum_in),
        .in_valid   (in_valid),
        .flush      (flush),
        .out_if     (out_if),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: rows issued per cycle, the buffered-row queue,
    // the sticky flag and the last cycle whose rows were cancelled.
    sum_row_t hist_row [HIST];
    bit       hist_v   [HIST];
    sum_row_t model_q  [$];
    bit       model_ovf;
    int       cyc;
    int       cancel_upto;

    int check_count;
    int pass_count;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkState();
        checkOutput("out_valid", 64'(out_if.out_valid), 64'(model_q.size() > 0));
        checkOutput("fifo_count", 64'(fifo_count), 64'(model_q.size()));
        checkOutput("overflow", 64'(overflow), 64'(model_ovf));
        if (model_q.size() > 0) begin
            checkOutput("out_data", 64'(out_if.out_data), 64'(model_q[0]));
        end
    endtask

    // One clock cycle: drive the skewed columns of every row issued in the
    // last W cycles, then apply the FIFO rules to the model at the edge.
    task automatic applyStimulus(input bit inv, input sum_row_t row, input bit fl, input bit rdy);
        sum_row_t s;
        sum_row_t r;
        int       al;
        bit       push;
        bit       pop;
        @(negedge clk);
        hist_v[cyc]   = inv;
        hist_row[cyc] = row;
        for (int k = 0; k < W; k++) begin
            if (cyc - k >= 0 && hist_v[cyc - k]) begin
                r = hist_row[cyc - k];
                s[k*SW +: SW] = r[k*SW +: SW];
            end else begin
                s[k*SW +: SW] = SW'($urandom);
            end
        end
        sum_in           = s;
        in_valid         = inv;
        flush            = fl;
        out_if.out_ready = rdy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            model_ovf   = 1'b0;
            cancel_upto = cyc;
        end else begin
            pop  = (model_q.size() > 0) && rdy;
            al   = cyc - (W - 1);
            push = (al >= 0) && (al > cancel_upto) && hist_v[al];
            if (push && model_q.size() == DEPTH && !pop) begin
                model_ovf = 1'b1;
            end else begin
                if (pop) void'(model_q.pop_front());
                if (push) model_q.push_back(hist_row[al]);
            end
        end
        cyc++;
        #1;
        checkState();
    endtask

    task automatic doReset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput("reset out_valid", 64'(out_if.out_valid), 64'd0);
        checkOutput("reset fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset out_data", 64'(out_if.out_data), 64'd0);
        model_q.delete();
        model_ovf   = 1'b0;
        cancel_upto = cyc - 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic sum_row_t rowOf(input int v);
        return {4{16'(v)}};
    endfunction

    initial begin
        check_count      = 0;
        pass_count       = 0;
        cyc              = 0;
        cancel_upto      = -1;
        model_ovf        = 1'b0;
        rst_n            = 1'b0;
        sum_in           = '0;
        in_valid         = 1'b0;
        flush            = 1'b0;
        out_if.out_ready = 1'b0;
        #1;
        checkOutput("reset out_valid", 64'(out_if.out_valid), 64'd0);
        checkOutput("reset fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset out_data", 64'(out_if.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single row with distinct column values.
        applyStimulus(1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Overflow: six back-to-back rows, no consumer, then drain.
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, rowOf(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Full FIFO with a simultaneous pop from the cycle row 5 aligns.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i < 6, rowOf(i + 1), 1'b0, i >= 7);
        end

        // Flush mid-stream with two rows buffered and overflow set.
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, rowOf(i + 16), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Reset with three rows stored and one still in the deskew chain.
        for (int i = 0; i < 6; i++) applyStimulus(i < 4, rowOf(i + 40), 1'b0, 1'b0);
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 3) != 0, {$urandom, $urandom},
                          ($urandom % 64) == 0, ($urandom % 4) != 0);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sits directly downstream of the systolic array top and consumes its bottom-row partial-sum vector in weight-stationary compute mode.
- Columns leave the array skewed: column k lags column 0 by k cycles. This block deskews them into one aligned row and buffers rows in a small FIFO.
- Rows are presented on a valid/ready stream to the writeback stage.
- The array cannot stall, so backpressure is absorbed by the FIFO. Excess rows are dropped and reported via a sticky overflow flag.

Parameters:
- SYSTOLIC_WIDTH, 4, number of array columns (>=2).
- SUM_WIDTH, 16, bits per partial sum.
- FIFO_DEPTH, 4, aligned rows buffered (power of 2, >=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sum_in  input  SYSTOLIC_WIDTH*SUM_WIDTH  array bottom-row sums; column k at [k*SUM_WIDTH +: SUM_WIDTH].
- in_valid  input  1  column-0 element of sum_in valid this cycle; column k of the same row is valid k cycles later.
- flush  input  1  synchronous clear of deskew valids, FIFO and overflow.
- out_data  output  SYSTOLIC_WIDTH*SUM_WIDTH  aligned row, same column packing as sum_in.
- out_valid  output  1  out_data holds a row.
- out_ready  input  1  consumer accepts the row when out_valid & out_ready.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  rows currently stored.
- overflow  output  1  sticky: a row was dropped.

Behaviour:
- Reset (async assert, sync release):
  - All deskew registers and valid pipeline clear to 0.
  - FIFO pointers and count clear to 0.
  - out_valid=0, out_data=0, fifo_count=0, overflow=0.
- Deskew:
  - Column k passes through a register chain of depth SYSTOLIC_WIDTH-1-k. Column SYSTOLIC_WIDTH-1 has depth 0, i.e. a wire.
  - in_valid passes through a SYSTOLIC_WIDTH-1 stage valid chain.
  - An aligned row plus its aligned valid exist combinationally in cycle t+SYSTOLIC_WIDTH-1 when in_valid was high in cycle t.
  - Deskew chains never stall; they shift every cycle.
- Push: the aligned row is written into the FIFO at the clock edge ending cycle t+SYSTOLIC_WIDTH-1.
- Latency: with the FIFO empty, out_valid rises in cycle t+SYSTOLIC_WIDTH.
  - out_data is driven from FIFO storage at the read pointer (first-word-fall-through).
  - No combinational bypass from sum_in to out_data.
- Pop: occurs on a rising edge when out_valid & out_ready. The next row, if any, appears in the following cycle.
  - out_data is held stable while out_valid & !out_ready.
- Back-to-back: in_valid may be high every cycle. One row is pushed per cycle and one popped per cycle, so full throughput holds with out_ready=1.
- Full FIFO:
  - Push while full and no pop that cycle: the row is dropped, overflow sets, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, count stays FIFO_DEPTH, and overflow is not set.
- Empty FIFO: out_valid=0. out_ready is ignored and no pop occurs.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are decided from fifo_count.
- Overflow clearing: the flag stays 1 until flush or reset.
- Flush (synchronous, priority over push/pop in the same cycle):
  - Clears the valid chain, pointers, count and overflow. out_valid=0 the next cycle.
  - Deskew data registers need not clear.
  - Rows whose column 0 was accepted before the flush edge are discarded.
- Arithmetic: no arithmetic on sums; pure transport. Widths are preserved bit-exactly.

Decomposition:
- Shared package systolic_pkg holds:
  - Default SYSTOLIC_WIDTH and SUM_WIDTH constants.
  - A typedef for one packed sum row (logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]).
- The top-level collector holds the per-column deskew chains and the valid chain.
- One sub-module is natural: sum_row_fifo, a synchronous FWFT FIFO with count and full/empty. It is parameterised on width and depth and instantiated once.

Test Plan:
All scenarios use SYSTOLIC_WIDTH=4, SUM_WIDTH=16, FIFO_DEPTH=4.
- Single row:
  - Stimulus: in_valid high in cycle 0. Column values 0x0001@c0, 0x0002@c1 (col 1), 0x0003@c2 (col 2), 0x0004@c3 (col 3). out_ready=1.
  - Response: out_valid=1 only in cycle 4, out_data=0x0004_0003_0002_0001, fifo_count back to 0.
- Overflow:
  - Stimulus: 6 back-to-back rows with column values equal to the row index 1..6. out_ready=0.
  - Response: fifo_count=4 and overflow=1 after row 5 is aligned. Then out_ready=1 drains rows 1,2,3,4 in order. overflow remains 1.
- Full with simultaneous pop:
  - Stimulus: fill the FIFO to 4. Then hold out_ready=1 while rows 5 and 6 arrive.
  - Response: no overflow, count stays 4, and output order is 1..6.
- Flush mid-stream:
  - Stimulus: flush asserted 2 cycles after in_valid for row A, with the FIFO holding 2 rows and overflow=1.
  - Response: next cycle fifo_count=0, out_valid=0, overflow=0. Row A never appears. A row issued after the flush emerges 4 cycles later, uncorrupted.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously with 3 rows stored and one in the deskew chain.
  - Response: immediately out_valid=0, fifo_count=0, overflow=0, out_data=0. After release no stale row appears.
